instr_fetch_unit: RTL and testbench

- Upstream fetch stage for the RV32I core. Owns the fetch PC and issues word requests to instruction memory.
- Buffers returned instructions, tagged with their PC, in a small in-order queue. The head entry is presented to the decode/control stage.
- Applies taken-branch/jump redirects (PCSel plus the ALU target) and discards stale in-flight responses.

---
 rtl/instr_fetch_unit.sv | 95 +++++++++
 tb/tb_instr_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage: issues imem requests under a credit limit and
// buffers PC-tagged responses in an in-order queue. Redirects flush the queue and drop stale responses.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(2 * DEPTH + 1);
    localparam logic [CW-1:0] D1 = CW'(DEPTH);
    localparam logic [CW-1:0] D2 = CW'(2 * DEPTH);
    localparam logic [PW-1:0] PL = PW'(DEPTH - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] fpc_q, fpc_d;
    logic [31:0] qpc_q [DEPTH];
    logic [31:0] qins_q [DEPTH];
    logic [31:0] tag_q [DEPTH];
    logic [PW-1:0] qwp_q, qrp_q, twp_q, trp_q;
    logic [CW-1:0] qcnt_q, qcnt_d, live_q, live_d, drop_q, drop_d;
    logic fire, redir, acc, keep;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PL ? '0 : p + PW'(1);
    endfunction

    assign instr_valid    = qcnt_q != '0;
    assign fire           = instr_valid & instr_ready;
    assign redir          = redirect_valid & fire;
    assign imem_req_valid = ~rst & ~redir & (live_q + qcnt_q < D1) & (live_q + drop_q < D2);
    assign imem_req_addr  = fpc_q;
    assign acc            = imem_req_valid & imem_req_ready;
    assign keep           = imem_rsp_valid & (drop_q == '0);
    assign instr          = instr_valid ? qins_q[qrp_q] : NOP;
    assign instr_pc       = instr_valid ? qpc_q[qrp_q] : 32'h0;
    assign instr_pc_plus4 = instr_pc + 32'd4;

    // A response arriving in the redirect cycle is stale too, hence the minus one.
    always_comb begin
        fpc_d  = redir ? (redirect_target & 32'hFFFF_FFFC) : acc ? fpc_q + 32'd4 : fpc_q;
        qcnt_d = redir ? '0 : qcnt_q + CW'(keep) - CW'(fire);
        live_d = redir ? '0 : live_q + CW'(acc) - CW'(keep);
        drop_d = redir ? drop_q + live_q - CW'(imem_rsp_valid) : drop_q - CW'(imem_rsp_valid & ~keep);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q  <= RESET_PC;
            qcnt_q <= '0;
            live_q <= '0;
            drop_q <= '0;
            qwp_q  <= '0;
            qrp_q  <= '0;
            twp_q  <= '0;
            trp_q  <= '0;
        end else begin
            fpc_q  <= fpc_d;
            qcnt_q <= qcnt_d;
            live_q <= live_d;
            drop_q <= drop_d;
            if (redir) begin
                qwp_q <= '0;
                qrp_q <= '0;
                twp_q <= '0;
                trp_q <= '0;
            end else begin
                if (keep) begin
                    qpc_q[qwp_q]  <= tag_q[trp_q];
                    qins_q[qwp_q] <= imem_rsp_data;
                    qwp_q         <= inc(qwp_q);
                    trp_q         <= inc(trp_q);
                end
                if (fire) qrp_q <= inc(qrp_q);
                if (acc) begin
                    tag_q[twp_q] <= fpc_q;
                    twp_q        <= inc(twp_q);
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench with an in-order latency memory model and a
// reference fetch-PC model; a second instance checks RESET_PC wrap.
module tb_instr_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic clk = 1'b0, rst = 1'b1;
    logic imem_req_valid, imem_req_ready = 1'b1, imem_rsp_valid = 1'b0;
    logic [31:0] imem_req_addr, imem_rsp_data = 32'h0;
    logic instr_valid, instr_ready = 1'b0, redirect_valid = 1'b0;
    logic [31:0] instr, instr_pc, instr_pc_plus4, redirect_target = 32'h0;
    logic w_req_valid, w_instr_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;

    req_t mem[$];
    logic [31:0] exp_q[$];
    logic [31:0] nfpc, rd_pc, rd_tgt, rd_first_pc;
    logic [31:0] wlog[2];
    int cyc, lat, ndel, nacc, nrd, first_acc, first_fire, n_chk, n_fail;
    logic rnd, rd_arm, rd_hold, rd_rsp, post_rd;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_addr),
        .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
        .instr_valid(w_instr_valid), .instr_ready(1'b0), .instr(w_instr),
        .instr_pc(w_pc), .instr_pc_plus4(w_pc4),
        .redirect_valid(1'b0), .redirect_target(32'h0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    // Called at a falling edge: drive this cycle's inputs, settle, score, advance.
    task automatic step();
        logic f;
        int l;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (mem.size() > 0 && mem[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = dat(mem[0].addr);
            void'(mem.pop_front());
        end
        if (rnd) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            instr_ready    = 1'($urandom_range(0, 1));
        end
        #1;
        f = instr_valid & instr_ready;
        redirect_target = rnd ? $urandom : rd_tgt;
        redirect_valid  = rd_hold | (f & ((rd_arm & (instr_pc == rd_pc)) | (rnd & ($urandom_range(0, 7) == 0))));
        #1;
        if (cyc < 2) wlog[cyc] = w_req_valid ? w_addr : 32'hDEAD_BEEF;
        if (imem_rsp_valid && dut.drop_q == 0) chk("no_overflow", 32'(dut.qcnt_q == 2 && !f), 0);
        if (f) begin
            chk("exp_avail", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                chk("instr_pc", instr_pc, exp_q[0]);
                chk("instr", instr, dat(exp_q[0]));
                chk("instr_pc_plus4", instr_pc_plus4, exp_q[0] + 32'd4);
                void'(exp_q.pop_front());
            end
            if (post_rd) rd_first_pc = instr_pc;
            post_rd = 1'b0;
            if (first_fire < 0) first_fire = cyc;
            ndel++;
            if (redirect_valid) begin
                chk("rd_noreq", 32'(imem_req_valid), 0);
                exp_q.delete();
                nfpc    = redirect_target & 32'hFFFF_FFFC;
                rd_arm  = 1'b0;
                post_rd = 1'b1;
                nrd++;
                if (imem_rsp_valid) rd_rsp = 1'b1;
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, nfpc);
            l = rnd ? $urandom_range(1, 4) : lat;
            exp_q.push_back(nfpc);
            mem.push_back('{imem_req_addr, cyc + l});
            nfpc += 32'd4;
            if (first_acc < 0) first_acc = cyc;
            nacc++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        {rd_hold, rd_arm, rnd, rd_rsp, post_rd} = '0;
        @(negedge clk);
        #1;
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        mem.delete();
        exp_q.delete();
        nfpc = 32'h0;
        rd_first_pc = 32'hDEAD_BEEF;
        {cyc, ndel, nacc, nrd} = '0;
        first_acc = -1;
        first_fire = -1;
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rd_pc = 0;
        rd_tgt = 0;
        // zero-wait memory, always ready
        lat = 1;
        do_reset();
        instr_ready = 1'b1;
        run(12);
        chk("first_acc_cycle", 32'(first_acc), 0);
        chk("first_fire_cycle", 32'(first_fire), 2);
        chk("wrap_first", wlog[0], 32'hFFFF_FFFC);
        chk("wrap_second", wlog[1], 32'h0);
        chk("t1_progress", 32'(ndel >= 4), 1);
        // consumer stalled: credit limit caps outstanding work at DEPTH
        do_reset();
        run(10);
        #1;
        chk("stall_accepts", 32'(nacc), 2);
        chk("stall_req_valid", 32'(imem_req_valid), 0);
        chk("stall_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        run(10);
        chk("stall_release", 32'(ndel >= 3), 1);
        // 3-cycle memory, redirect with misaligned target
        lat = 3;
        do_reset();
        instr_ready = 1'b1;
        {rd_arm, rd_pc, rd_tgt} = {1'b1, 32'h8, 32'h103};
        run(30);
        chk("t3_redirects", 32'(nrd), 1);
        chk("t3_first_after_rd", rd_first_pc, 32'h100);
        chk("t3_drop_zero", 32'(dut.drop_q), 0);
        // redirect coinciding with a response
        lat = 1;
        do_reset();
        instr_ready = 1'b1;
        {rd_arm, rd_pc, rd_tgt} = {1'b1, 32'h8, 32'h200};
        run(20);
        chk("t4_rd_with_rsp", 32'(rd_rsp), 1);
        chk("t4_first_after_rd", rd_first_pc, 32'h200);
        chk("t4_drop_zero", 32'(dut.drop_q), 0);
        // redirect_valid without fire is ignored
        lat = 2;
        do_reset();
        run(4);
        rd_tgt = 32'h300;
        rd_hold = 1'b1;
        run(6);
        rd_hold = 1'b0;
        instr_ready = 1'b1;
        run(10);
        chk("t5_no_redirect", 32'(nrd), 0);
        chk("t5_progress", 32'(ndel >= 3), 1);
        // reset mid-stream with two requests outstanding
        lat = 3;
        do_reset();
        instr_ready = 1'b1;
        run(2);
        chk("t6_outstanding", 32'(mem.size()), 2);
        do_reset();
        instr_ready = 1'b1;
        run(10);
        chk("t6_first_acc", 32'(first_acc), 0);
        chk("t6_progress", 32'(ndel >= 2), 1);
        // random ready, latency and redirects
        do_reset();
        rnd = 1'b1;
        run(3000);
        chk("rand_progress", 32'(ndel > 100), 1);
        chk("rand_redirects", 32'(nrd > 10), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
